pio_keyseg_ctrl: RTL and testbench

//  Parametrised successor to the mypio conduit block: an Avalon-MM slave exposing LEDs, debounced switches/keys, a sticky
//  key-edge capture with a maskable IRQ, and a time-multiplexed hex 7-segment driver. Sits in soc_system on the

---
 rtl/pio_keyseg_if.sv | 29 ++
 rtl/pio_keyseg_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_pio_keyseg_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_keyseg_if.sv
// ----------------------------------------------------------------------------
// pio_keyseg_if
//   Avalon-MM slave bundle for pio_keyseg_ctrl: word-addressed register
//   access plus the level interrupt line.
//   avs_address    word address (3 bits)
//   avs_read       read strobe; avs_readdata valid one cycle later
//   avs_write      write strobe; register updates on the next clock edge
//   avs_writedata  32-bit write data
//   avs_readdata   32-bit registered read data
//   irq            level interrupt, active-high
// ----------------------------------------------------------------------------
interface pio_keyseg_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, irq
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, irq
    );
endinterface

// File: rtl/pio_keyseg_ctrl.sv
// ----------------------------------------------------------------------------
// pio_keyseg_ctrl
//   Avalon-MM PIO block: LED register, debounced switches/keys, sticky
//   key-press capture with maskable level IRQ, and a time-multiplexed hex
//   7-segment driver.
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   avs         pio_keyseg_if.slave: register bus and irq
//   led         LED drive, active-high
//   switch      raw slide switches, asynchronous
//   key         raw push buttons, asynchronous, active-low
//   seg_output  {digit_sel_n[NUM_DIGITS-1:0], seg_n[7:0]}, active-low,
//               seg_n = {dp, g..a}
// Register map (word address)
//   0 LED RW, 1 IN RO {key_db, sw_db}, 2 EDGE W1C, 3 IRQMSK RW,
//   4 DIGITS RW (nibble per digit), 5 SEGCTL RW {en[31], dp[8+:N], blank[N-1:0]},
//   6/7 read 0, writes ignored
// ----------------------------------------------------------------------------
module pio_keyseg_ctrl #(
    parameter int LED_W        = 8,
    parameter int SW_W         = 4,
    parameter int KEY_W        = 2,
    parameter int NUM_DIGITS   = 4,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int SCAN_DIV     = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    pio_keyseg_if.slave             avs,
    output logic [LED_W-1:0]        led,
    input  logic [SW_W-1:0]         switch,
    input  logic [KEY_W-1:0]        key,
    output logic [NUM_DIGITS+7:0]   seg_output
);

    localparam int IN_W  = SW_W + KEY_W;
    localparam int CNT_W = $clog2(DEBOUNCE_CYC);
    localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Idle level of the inputs: keys released (high), switches low.
    localparam logic [IN_W-1:0] IN_RST = {{KEY_W{1'b1}}, {SW_W{1'b0}}};

    localparam logic [2:0] ADDR_LED    = 3'd0;
    localparam logic [2:0] ADDR_IN     = 3'd1;
    localparam logic [2:0] ADDR_EDGE   = 3'd2;
    localparam logic [2:0] ADDR_IRQMSK = 3'd3;
    localparam logic [2:0] ADDR_DIGITS = 3'd4;
    localparam logic [2:0] ADDR_SEGCTL = 3'd5;

    // Standard hex font, active-high g..a.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        hex7 = 7'h00;
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;  4'hF: hex7 = 7'h71;
            default: hex7 = 7'h00;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Input synchroniser and per-bit debounce
    // ------------------------------------------------------------------
    logic [IN_W-1:0]  sync_q1, sync_q2, in_db;
    logic [CNT_W-1:0] db_cnt [IN_W];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= IN_RST;
            sync_q2 <= IN_RST;
        end else begin
            sync_q1 <= {key, switch};
            sync_q2 <= sync_q1;
        end
    end

    // NOTE: the debounce counters are a handful of flops, not a RAM, so
    // they are reset like any other state; a real memory would not be.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_W; i++) begin
            if (reset) begin
                db_cnt[i] <= '0;
                in_db[i]  <= IN_RST[i];
            end else if (sync_q2[i] == in_db[i]) begin
                db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
                in_db[i]  <= sync_q2[i];
                db_cnt[i] <= '0;
            end else begin
                db_cnt[i] <= db_cnt[i] + CNT_W'(1);
            end
        end
    end

    logic [KEY_W-1:0] key_db, key_db_q, key_press;
    assign key_db    = in_db[IN_W-1:SW_W];
    assign key_press = key_db_q & ~key_db;   // debounced 1->0 transition

    // ------------------------------------------------------------------
    // Registers and bus
    // ------------------------------------------------------------------
    logic [LED_W-1:0]        led_reg;
    logic [KEY_W-1:0]        edge_flags, irq_mask, edge_clr;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   seg_blank, seg_dp;
    logic                    seg_en;
    logic                    irq_q;
    logic [31:0]             rd_next, rd_q;

    // Writedata bits beyond each register's width are dropped by design.
    logic wdata_unused;
    assign wdata_unused = ^avs.avs_writedata;

    assign edge_clr = (avs.avs_write && avs.avs_address == ADDR_EDGE)
                      ? avs.avs_writedata[KEY_W-1:0] : '0;

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_next = '0;
        if (avs.avs_read) begin
            case (avs.avs_address)
                ADDR_LED:    rd_next[LED_W-1:0]        = led_reg;
                ADDR_IN:     rd_next[IN_W-1:0]         = in_db;
                ADDR_EDGE:   rd_next[KEY_W-1:0]        = edge_flags;
                ADDR_IRQMSK: rd_next[KEY_W-1:0]        = irq_mask;
                ADDR_DIGITS: rd_next[4*NUM_DIGITS-1:0] = digits;
                ADDR_SEGCTL: begin
                    rd_next[NUM_DIGITS-1:0]  = seg_blank;
                    rd_next[8 +: NUM_DIGITS] = seg_dp;
                    rd_next[31]              = seg_en;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_reg    <= '0;
            edge_flags <= '0;
            irq_mask   <= '0;
            digits     <= '0;
            seg_blank  <= '0;
            seg_dp     <= '0;
            seg_en     <= 1'b0;
            key_db_q   <= '1;
            irq_q      <= 1'b0;
            rd_q       <= '0;
        end else begin
            key_db_q <= key_db;
            // A press arriving with a W1C of the same bit wins.
            edge_flags <= (edge_flags & ~edge_clr) | key_press;
            irq_q      <= |(edge_flags & irq_mask);
            rd_q       <= rd_next;
            if (avs.avs_write) begin
                case (avs.avs_address)
                    ADDR_LED:    led_reg  <= avs.avs_writedata[LED_W-1:0];
                    ADDR_IRQMSK: irq_mask <= avs.avs_writedata[KEY_W-1:0];
                    ADDR_DIGITS: digits   <= avs.avs_writedata[4*NUM_DIGITS-1:0];
                    ADDR_SEGCTL: begin
                        seg_blank <= avs.avs_writedata[NUM_DIGITS-1:0];
                        seg_dp    <= avs.avs_writedata[8 +: NUM_DIGITS];
                        seg_en    <= avs.avs_writedata[31];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign led              = led_reg;
    assign avs.avs_readdata = rd_q;
    assign avs.irq          = irq_q;

    // ------------------------------------------------------------------
    // 7-segment scan
    // ------------------------------------------------------------------
    logic [PS_W-1:0]        prescale;
    logic [IDX_W-1:0]       scan_idx;
    logic [NUM_DIGITS-1:0]  sel_n;
    logic [7:0]             seg_n;
    logic [3:0]             nibble;
    logic [NUM_DIGITS+7:0]  seg_next;

    always_ff @(posedge clk) begin
        if (reset || !seg_en) begin
            prescale <= '0;
            scan_idx <= '0;
        end else if (prescale == PS_W'(SCAN_DIV - 1)) begin
            prescale <= '0;
            scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0
                                                             : scan_idx + IDX_W'(1);
        end else begin
            prescale <= prescale + PS_W'(1);
        end
    end

    always_comb begin
        sel_n           = '1;
        seg_n           = '1;
        nibble          = digits[{scan_idx, 2'b00} +: 4];
        seg_next        = '1;
        sel_n[scan_idx] = 1'b0;
        if (!seg_blank[scan_idx]) begin
            seg_n = ~{seg_dp[scan_idx], hex7(nibble)};
        end
        if (seg_en) begin
            seg_next = {sel_n, seg_n};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_output <= '1;
        end else begin
            seg_output <= seg_next;
        end
    end

endmodule

// File: tb/tb_pio_keyseg_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pio_keyseg_ctrl
//   Self-checking bench for pio_keyseg_ctrl with DEBOUNCE_CYC=4, SCAN_DIV=3.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_pio_keyseg_ctrl;

    localparam int DEB  = 4;
    localparam int DIV  = 3;
    localparam int NDIG = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  led;
    logic [3:0]  sw;
    logic [1:0]  key;
    logic [11:0] seg;

    always #5 clk = ~clk;

    pio_keyseg_if bus ();

    pio_keyseg_ctrl #(
        .LED_W(8), .SW_W(4), .KEY_W(2), .NUM_DIGITS(NDIG),
        .DEBOUNCE_CYC(DEB), .SCAN_DIV(DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .avs        (bus),
        .led        (led),
        .switch     (sw),
        .key        (key),
        .seg_output (seg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        @(negedge clk);
        bus.avs_read    = 1'b0;
        d = bus.avs_readdata;
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    // Reference: standard hex font, active-high g..a.
    logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [11:0] exp_seg(input int d, input logic [15:0] digs,
                                            input logic [3:0] blank, input logic [3:0] dp);
        logic [3:0] sel;
        logic [7:0] s;
        logic [3:0] nib;
        sel = ~(4'b0001 << d);
        nib = 4'((digs >> (4 * d)) & 16'hF);
        s   = blank[d] ? 8'hFF : ~{dp[d], font[nib]};
        return {sel, s};
    endfunction

    // After enable is written (sample 0), sample k shows digit ((k-1)/DIV) mod NDIG.
    task automatic scan_check(input string name, input logic [15:0] digs,
                              input logic [3:0] blank, input logic [3:0] dp, input int n);
        check({name, " k0"}, 32'(seg), 32'hFFF);
        for (int k = 1; k <= n; k++) begin
            cyc(1);
            check($sformatf("%s k%0d", name, k), 32'(seg),
                  32'(exp_seg(((k - 1) / DIV) % NDIG, digs, blank, dp)));
        end
    endtask

    function automatic logic [31:0] reg_mask(input logic [2:0] a);
        case (a)
            3'd0:    return 32'h0000_00FF;
            3'd3:    return 32'h0000_0003;
            3'd4:    return 32'h0000_FFFF;
            3'd5:    return 32'h8000_0F0F;
            default: return 32'h0;
        endcase
    endfunction

    typedef struct {
        string       name;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rexp;
    } rw_vec_t;

    rw_vec_t vecs [8];

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] mdl [8];
        logic [3:0]  sw_cur;

        vecs[0] = '{"rw led all", 3'd0, 32'hFFFF_FFFF, 32'h0000_00FF};
        vecs[1] = '{"rw led hi",  3'd0, 32'h1234_5600, 32'h0000_0000};
        vecs[2] = '{"rw irqmsk",  3'd3, 32'hFFFF_FFFF, 32'h0000_0003};
        vecs[3] = '{"rw digits",  3'd4, 32'hDEAD_BEEF, 32'h0000_BEEF};
        vecs[4] = '{"rw segctl",  3'd5, 32'hFFFF_FFFF, 32'h8000_0F0F};
        vecs[5] = '{"rw segctl0", 3'd5, 32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{"rw addr6",   3'd6, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[7] = '{"rw addr7",   3'd7, 32'hFFFF_FFFF, 32'h0000_0000};

        reset = 1'b1;
        sw = 4'h0;
        key = 2'b11;
        bus.avs_address = '0;
        bus.avs_read = 1'b0;
        bus.avs_write = 1'b0;
        bus.avs_writedata = '0;
        cyc(3);
        reset = 1'b0;

        // Reset state
        check("reset led", 32'(led), 32'h0);
        check("reset readdata", bus.avs_readdata, 32'h0);
        check("reset irq", 32'(bus.irq), 32'h0);
        check("reset seg", 32'(seg), 32'hFFF);
        read_check("reset in", 3'd1, 32'h30);
        read_check("reset edge", 3'd2, 32'h0);

        // Test 1: LED write and readback
        bus_write(3'd0, 32'hA5);
        check("led pin", 32'(led), 32'hA5);
        read_check("led read", 3'd0, 32'hA5);

        // Register map vectors
        foreach (vecs[i]) begin
            bus_write(vecs[i].addr, vecs[i].wdata);
            read_check(vecs[i].name, vecs[i].addr, vecs[i].rexp);
        end

        // Read and write in the same cycle: read sees the old value
        bus_write(3'd0, 32'h11);
        bus.avs_address = 3'd0;
        bus.avs_writedata = 32'h22;
        bus.avs_read = 1'b1;
        bus.avs_write = 1'b1;
        cyc(1);
        bus.avs_read = 1'b0;
        bus.avs_write = 1'b0;
        check("rd/wr same cycle", bus.avs_readdata, 32'h11);
        read_check("rd/wr after", 3'd0, 32'h22);

        // Test 2: switch debounce and glitch rejection
        sw = 4'b1010;
        cyc(10);
        read_check("sw settle", 3'd1, 32'h3A);
        sw = 4'b1011;
        cyc(2);
        sw = 4'b1010;
        cyc(10);
        read_check("sw glitch", 3'd1, 32'h3A);

        // Test 3: key press, edge capture, IRQ and W1C
        bus_write(3'd3, 32'h1);
        key = 2'b10;
        cyc(8);
        check("irq set", 32'(bus.irq), 32'h1);
        key = 2'b11;
        cyc(10);
        read_check("edge set", 3'd2, 32'h1);
        bus_write(3'd2, 32'h1);
        check("irq lag", 32'(bus.irq), 32'h1);
        cyc(1);
        check("irq clear", 32'(bus.irq), 32'h0);
        read_check("edge clear", 3'd2, 32'h0);

        // Test 4: press of key[1] lands on the same edge as a W1C of EDGE[1].
        // Debounced key falls 6 edges after the raw change; the press is
        // registered into EDGE on the 7th edge.
        key = 2'b01;
        cyc(6);
        bus_write(3'd2, 32'h2);
        key = 2'b11;
        cyc(10);
        read_check("press vs w1c", 3'd2, 32'h2);
        check("irq masked", 32'(bus.irq), 32'h0);
        bus_write(3'd2, 32'h2);
        read_check("edge1 w1c", 3'd2, 32'h0);

        // Test 5: scan 0x1234, all digits visible
        bus_write(3'd5, 32'h0);
        bus_write(3'd4, 32'h1234);
        bus_write(3'd5, 32'h8000_0000);
        scan_check("scan plain", 16'h1234, 4'b0000, 4'b0000, 24);

        // Test 6: blank digit 1, dp on digit 0, then disable
        bus_write(3'd5, 32'h0);
        bus_write(3'd5, 32'h8000_0102);
        scan_check("scan blank/dp", 16'h1234, 4'b0010, 4'b0001, 24);
        bus_write(3'd5, 32'h0000_0102);
        cyc(1);
        check("seg disabled", 32'(seg), 32'hFFF);
        cyc(5);
        check("seg disabled hold", 32'(seg), 32'hFFF);

        // Randomised switch values with sub-threshold glitches
        for (int i = 0; i < 6; i++) begin
            sw_cur = 4'($urandom);
            sw = sw_cur;
            cyc(10);
            read_check($sformatf("rand sw %0d", i), 3'd1, {26'h0, 2'b11, sw_cur});
            sw = sw_cur ^ 4'($urandom_range(1, 15));
            cyc($urandom_range(1, DEB - 1));
            sw = sw_cur;
            cyc(10);
            read_check($sformatf("rand glitch %0d", i), 3'd1, {26'h0, 2'b11, sw_cur});
        end

        // Randomised register traffic against a register-map model
        foreach (mdl[a]) begin
            mdl[a] = 32'h0;
        end
        bus_write(3'd0, 32'h0);
        bus_write(3'd2, 32'h3);
        bus_write(3'd3, 32'h0);
        bus_write(3'd4, 32'h0);
        bus_write(3'd5, 32'h0);
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  a;
            logic [31:0] wd, exp;
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                bus_write(a, wd);
                if (reg_mask(a) != 32'h0) begin
                    mdl[a] = wd & reg_mask(a);
                end
            end else begin
                exp = (a == 3'd1) ? {26'h0, 2'b11, sw_cur} : mdl[a];
                read_check($sformatf("rand reg a%0d #%0d", a, i), a, exp);
            end
        end
        for (int a = 0; a < 8; a++) begin
            logic [31:0] exp;
            exp = (a == 1) ? {26'h0, 2'b11, sw_cur} : mdl[a];
            read_check($sformatf("rand final a%0d", a), 3'(a), exp);
        end
        check("rand irq idle", 32'(bus.irq), 32'h0);

        // Reset mid-operation
        sw = 4'b0110;
        cyc(10);
        bus_write(3'd0, 32'h5A);
        bus_write(3'd4, 32'h1234);
        bus_write(3'd5, 32'h8000_0000);
        cyc(4);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("midrst led", 32'(led), 32'h0);
        check("midrst seg", 32'(seg), 32'hFFF);
        check("midrst irq", 32'(bus.irq), 32'h0);
        read_check("midrst in", 3'd1, 32'h30);
        read_check("midrst led reg", 3'd0, 32'h0);
        read_check("midrst segctl", 3'd5, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
